// File: rtl/fpnew_inorder_retire_if.sv
// fpnew_inorder_retire_if: issue/writeback/retire bus; master = dispatch+groups+core side, slave = reorder buffer
interface fpnew_inorder_retire_if #(
  parameter int Width     = 64,
  parameter int NumGroups = 4,
  parameter int Depth     = 8,
  parameter int TagWidth  = 1
);
  localparam int IdW  = $clog2(Depth);
  localparam int GrpW = NumGroups > 1 ? $clog2(NumGroups) : 1;
  logic                                issue_valid, issue_ready;
  logic [GrpW-1:0]                     issue_grp;
  logic [TagWidth-1:0]                 issue_tag;
  logic [IdW-1:0]                      issue_id;
  logic [NumGroups-1:0]                wb_valid, wb_ready;
  logic [NumGroups-1:0][IdW-1:0]       wb_id;
  logic [NumGroups-1:0][Width-1:0]     wb_result;
  logic [NumGroups-1:0][4:0]           wb_status;
  logic                                out_valid, out_ready;
  logic [Width-1:0]                    result;
  logic [4:0]                          status;
  logic [TagWidth-1:0]                 tag;
  modport master (
    output issue_valid, issue_grp, issue_tag, wb_valid, wb_id, wb_result, wb_status, out_ready,
    input  issue_ready, issue_id, wb_ready, out_valid, result, status, tag
  );
  modport slave (
    input  issue_valid, issue_grp, issue_tag, wb_valid, wb_id, wb_result, wb_status, out_ready,
    output issue_ready, issue_id, wb_ready, out_valid, result, status, tag
  );
endinterface

// File: rtl/fpnew_inorder_retire.sv
// fpnew_inorder_retire: circular reorder buffer retiring FPU group results in issue order; ports clk_i, rst_ni, flush_i, bus (issue/wb/out), occupancy_o, busy_o, err_o
module fpnew_inorder_retire #(
  parameter int Width     = 64,
  parameter int NumGroups = 4,
  parameter int Depth     = 8,
  parameter int TagWidth  = 1,
  localparam int IdW  = $clog2(Depth),
  localparam int GrpW = NumGroups > 1 ? $clog2(NumGroups) : 1,
  localparam int CntW = $clog2(Depth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  fpnew_inorder_retire_if.slave bus,
  output logic [CntW-1:0]       occupancy_o,
  output logic                  busy_o,
  output logic                  err_o
);
  logic [Depth-1:0]                valid_q, valid_d, done_q, done_d;
  logic [Depth-1:0][GrpW-1:0]      grp_q, grp_d;
  logic [Depth-1:0][TagWidth-1:0]  tag_q, tag_d;
  logic [Depth-1:0][Width-1:0]     res_q, res_d;
  logic [Depth-1:0][4:0]           st_q, st_d;
  logic [IdW-1:0]                  head_q, head_d, tail_q, tail_d, id;
  logic [CntW-1:0]                 cnt_q, cnt_d;
  logic                            err_q, err_d, issue_fire, retire;
  assign bus.issue_ready = cnt_q != CntW'(Depth);
  assign bus.issue_id    = tail_q;
  assign bus.wb_ready    = '1;
  assign bus.out_valid   = valid_q[head_q] & done_q[head_q];
  assign bus.result      = bus.out_valid ? res_q[head_q] : '0;
  assign bus.status      = bus.out_valid ? st_q[head_q] : '0;
  assign bus.tag         = bus.out_valid ? tag_q[head_q] : '0;
  assign occupancy_o     = cnt_q;
  assign busy_o          = cnt_q != '0;
  assign err_o           = err_q;
  assign issue_fire      = bus.issue_valid & bus.issue_ready;
  assign retire          = bus.out_valid & bus.out_ready;
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    grp_d   = grp_q;
    tag_d   = tag_q;
    res_d   = res_q;
    st_d    = st_q;
    head_d  = head_q;
    tail_d  = tail_q;
    err_d   = err_q;
    id      = '0;
    for (int g = 0; g < NumGroups; g++) begin
      id = bus.wb_id[g];
      if (bus.wb_valid[g]) begin
        if (valid_q[id] && !done_q[id] && grp_q[id] == GrpW'(g)) begin
          done_d[id] = 1'b1;
          res_d[id]  = bus.wb_result[g];
          st_d[id]   = bus.wb_status[g];
        end else err_d = 1'b1;
      end
    end
    if (retire) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      head_d          = head_q + IdW'(1);
    end
    // a non-full buffer never has tail on a live entry, so this cannot collide with the retire above
    if (issue_fire) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      grp_d[tail_q]   = bus.issue_grp;
      tag_d[tail_q]   = bus.issue_tag;
      tail_d          = tail_q + IdW'(1);
    end
    cnt_d = cnt_q + CntW'(issue_fire) - CntW'(retire);
    // flush drops everything from this cycle, including writeback errors
    if (flush_i) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      cnt_d   = '0;
      err_d   = err_q;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      done_q  <= '0;
      grp_q   <= '0;
      tag_q   <= '0;
      res_q   <= '0;
      st_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      grp_q   <= grp_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      st_q    <= st_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_fpnew_inorder_retire.sv
// tb_fpnew_inorder_retire: scoreboard bench for the in-order retire buffer
module tb_fpnew_inorder_retire;
  localparam int W = 64, NG = 4, D = 8, TW = 4;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic [3:0] occ;
  logic busy, err;
  int checks = 0, errors = 0;
  fpnew_inorder_retire_if #(.Width(W), .NumGroups(NG), .Depth(D), .TagWidth(TW)) bus ();
  fpnew_inorder_retire #(.Width(W), .NumGroups(NG), .Depth(D), .TagWidth(TW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(bus),
    .occupancy_o(occ), .busy_o(busy), .err_o(err)
  );
  always #5 clk = ~clk;
  int exp_q[$];
  bit m_valid[D], m_done[D];
  int m_grp[D];
  logic [TW-1:0] m_tag[D];
  logic [W-1:0] m_res[D];
  logic [4:0] m_st[D];
  int m_tail = 0, ret_id = 0, rst_cnt = 0, rst_seen = 0;
  bit m_err = 0, ret_pending = 0;
  always @(negedge rst_n) rst_cnt++;
  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", n, a, e, $time);
    end
  endfunction
  function automatic void model_reset();
    for (int i = 0; i < D; i++) begin m_valid[i] = 0; m_done[i] = 0; end
    exp_q.delete();
    m_tail = 0; m_err = 0; ret_pending = 0;
  endfunction
  function automatic void model_update();
    int cnt;
    cnt = exp_q.size() + int'(ret_pending);
    if (flush) begin
      for (int i = 0; i < D; i++) begin m_valid[i] = 0; m_done[i] = 0; end
      exp_q.delete();
      m_tail = 0; ret_pending = 0;
      return;
    end
    for (int g = 0; g < NG; g++) if (bus.wb_valid[g]) begin
      int id;
      id = int'(bus.wb_id[g]);
      if (m_valid[id] && !m_done[id] && m_grp[id] == g) begin
        m_done[id] = 1; m_res[id] = bus.wb_result[g]; m_st[id] = bus.wb_status[g];
      end else m_err = 1;
    end
    if (ret_pending) begin m_valid[ret_id] = 0; m_done[ret_id] = 0; ret_pending = 0; end
    if (bus.issue_valid && cnt < D) begin
      m_valid[m_tail] = 1; m_done[m_tail] = 0;
      m_grp[m_tail] = int'(bus.issue_grp); m_tag[m_tail] = bus.issue_tag;
      exp_q.push_back(m_tail);
      m_tail = (m_tail + 1) % D;
    end
  endfunction
  function automatic void check();
    int h;
    bit ev;
    h = exp_q.size() > 0 ? exp_q[0] : 0;
    ev = exp_q.size() > 0 && m_done[h];
    chk("out_valid", 64'(bus.out_valid), 64'(ev));
    if (!ev) begin
      chk("idle_result", bus.result, 64'd0);
      chk("idle_status", 64'(bus.status), 64'd0);
      chk("idle_tag", 64'(bus.tag), 64'd0);
    end
    chk("occupancy", 64'(occ), 64'(exp_q.size()));
    chk("busy", 64'(busy), 64'(exp_q.size() != 0));
    chk("issue_ready", 64'(bus.issue_ready), 64'(exp_q.size() != D));
    chk("issue_id", 64'(bus.issue_id), 64'(m_tail));
    chk("err", 64'(err), 64'(m_err));
    chk("wb_ready", 64'(bus.wb_ready), 64'hf);
    if (bus.out_valid && bus.out_ready && !flush) begin
      if (exp_q.size() == 0) chk("retire_when_empty", 64'(bus.out_valid), 64'd0);
      else begin
        h = exp_q.pop_front();
        chk("retire_done", 64'(m_done[h]), 64'd1);
        chk("tag", 64'(bus.tag), 64'(m_tag[h]));
        chk("result", bus.result, m_res[h]);
        chk("status", 64'(bus.status), 64'(m_st[h]));
        ret_pending = 1; ret_id = h;
      end
    end
  endfunction
  initial forever begin
    @(negedge clk);
    if (rst_cnt != rst_seen) begin rst_seen = rst_cnt; model_reset(); end
    if (rst_n) check();
    @(posedge clk);
    if (rst_n) model_update();
  end
  task automatic tick();
    @(posedge clk);
    #1;
    bus.issue_valid = 0; bus.wb_valid = '0; flush = 0;
  endtask
  task automatic issue(int g, int t);
    bus.issue_valid = 1; bus.issue_grp = 2'(g); bus.issue_tag = 4'(t);
  endtask
  task automatic wb(int id, int g);
    bus.wb_valid[g] = 1'b1; bus.wb_id[g] = 3'(id);
    bus.wb_result[g] = {$urandom, $urandom}; bus.wb_status[g] = 5'($urandom);
  endtask
  task automatic complete_some(int pct);
    for (int g = 0; g < NG; g++) if ($urandom_range(0, 99) < pct) begin
      int c[$];
      foreach (exp_q[i]) if (!m_done[exp_q[i]] && m_grp[exp_q[i]] == g) c.push_back(exp_q[i]);
      if (c.size() > 0) wb(c[$urandom_range(0, c.size() - 1)], g);
    end
  endtask
  task automatic drain();
    bus.out_ready = 1;
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) begin complete_some(100); tick(); end
    tick();
    chk("drained", 64'(exp_q.size()), 64'd0);
  endtask
  initial begin
    int base, id;
    bus.issue_valid = 0; bus.issue_grp = '0; bus.issue_tag = '0;
    bus.wb_valid = '0; bus.wb_id = '0; bus.wb_result = '0; bus.wb_status = '0;
    bus.out_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    tick();
    bus.out_ready = 1;
    for (int i = 0; i < 3; i++) begin issue(i, i + 1); tick(); end
    for (int i = 0; i < 3; i++) begin wb(i, i); tick(); end
    repeat (3) tick();
    base = m_tail;
    for (int i = 0; i < 4; i++) begin issue($urandom_range(0, 3), $urandom_range(0, 15)); tick(); end
    foreach (exp_q[i]) ;
    id = (base + 3) % D; wb(id, m_grp[id]); tick();
    id = (base + 1) % D; wb(id, m_grp[id]); tick();
    id = base;           wb(id, m_grp[id]); tick();
    id = (base + 2) % D; wb(id, m_grp[id]); tick();
    repeat (5) tick();
    flush = 1; tick();
    bus.out_ready = 0;
    for (int i = 0; i < 9; i++) begin issue($urandom_range(0, 3), i); tick(); end
    for (int i = 0; i < D; i++) begin wb(i, m_grp[i]); tick(); end
    bus.out_ready = 1; repeat (3) tick(); bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin issue($urandom_range(0, 3), 9 + i); tick(); end
    drain();
    bus.out_ready = 0;
    issue(3, 5); tick();
    id = exp_q[$]; wb(id, 3); tick();
    repeat (4) tick();
    bus.out_ready = 1; repeat (2) tick();
    bus.out_ready = 0;
    wb(5, 0); tick();
    issue(1, 7); tick();
    id = exp_q[$];
    wb(id, 2); tick();
    wb(id, 1); tick();
    wb(id, 1); tick();
    bus.out_ready = 1; repeat (2) tick();
    bus.out_ready = 0;
    for (int i = 0; i < 5; i++) begin issue($urandom_range(0, 3), i); tick(); end
    wb(exp_q[0], m_grp[exp_q[0]]); tick();
    issue(0, 1); wb(exp_q[1], m_grp[exp_q[1]]); flush = 1; tick();
    tick();
    for (int i = 0; i < 5; i++) begin issue($urandom_range(0, 3), i); tick(); end
    complete_some(100); tick();
    #1 rst_n = 0;
    #1 rst_n = 1;
    tick();
    for (int c = 0; c < 400; c++) begin
      bus.out_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 1) == 1) issue($urandom_range(0, 3), $urandom_range(0, 15));
      complete_some(40);
      if ($urandom_range(0, 29) == 0) wb($urandom_range(0, D - 1), $urandom_range(0, NG - 1));
      if ($urandom_range(0, 99) == 0) flush = 1;
      tick();
    end
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpnew_inorder_retire.md
Name: fpnew_inorder_retire

Overview:
- Parametrised successor to the FPU top-level output arbiter.
- Round-robin arbitration returns results out of issue order. This block instead tracks every accepted operation in a circular reorder buffer and retires results strictly in issue order, with the full tag attached.
- Sits between the FPU input dispatch, the NumGroups operation-group blocks (which carry the buffer ID through their tag path) and the core writeback port.

Parameters:
- Width, 64, result width in bits.
- NumGroups, 4, number of operation-group writeback channels.
- Depth, 8, reorder buffer entries; power of two, ≥2.
- TagWidth, 1, width of the user tag carried with each operation.
- IdW (localparam), $clog2(Depth), buffer index width.
- GrpW (localparam), max(1,$clog2(NumGroups)), group index width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous flush of all in-flight entries.
- issue_valid_i  in  1  new operation dispatched.
- issue_ready_o  out  1  buffer can accept an operation.
- issue_grp_i  in  GrpW  group the operation was dispatched to.
- issue_tag_i  in  TagWidth  user tag.
- issue_id_o  out  IdW  entry index allocated to this issue (current tail).
- wb_valid_i  in  NumGroups  per-group result valid.
- wb_ready_o  out  NumGroups  per-group result accepted.
- wb_id_i  in  NumGroups×IdW  entry index returned with the result.
- wb_result_i  in  NumGroups×Width  result data.
- wb_status_i  in  NumGroups×5  fflags {NV,DZ,OF,UF,NX}.
- out_valid_o  out  1  head result available.
- out_ready_i  in  1  consumer accepts the head.
- result_o  out  Width  head result.
- status_o  out  5  head status.
- tag_o  out  TagWidth  head tag.
- occupancy_o  out  $clog2(Depth+1)  allocated entries.
- busy_o  out  1  occupancy_o != 0.
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset values: all entries invalid; head = tail = count = 0. Outputs: issue_ready_o=1, out_valid_o=0, result_o/status_o/tag_o=0, occupancy_o=0, busy_o=0, err_o=0, issue_id_o=0.
- Entry state: valid, done, grp, tag, result, status.
- Issue:
  - issue_ready_o = (count != Depth). It does not depend on issue_valid_i.
  - On a valid&ready edge, entry[tail] gets valid=1, done=0, grp, tag; tail increments modulo Depth.
  - issue_id_o = tail (combinational).
- Writeback:
  - wb_ready_o is tied all-ones; entries are pre-allocated, so writebacks never stall.
  - Channel g is accepted iff entry[wb_id_i[g]] is valid, not done, and its grp == g. On acceptance, result and status are stored and done=1 at the next edge.
  - Any other valid writeback is dropped and sets err_o.
  - Multiple channels may write distinct IDs in the same cycle; all are accepted.
  - If two channels target the same ID in the same cycle, at most one can match grp. The mismatching channel(s) are dropped and set err_o.
- Retire:
  - out_valid_o = entry[head].valid & entry[head].done.
  - result_o, status_o and tag_o show the head entry when out_valid_o=1, and 0 otherwise.
  - Latency: writeback on the head at edge N gives out_valid_o=1 in the cycle after N. There is no combinational wb→out bypass.
  - On out_valid_o & out_ready_i: the head is cleared and head increments modulo Depth.
  - out_valid_o is never deasserted by the block until accepted, except on flush.
- Count: +1 on issue, −1 on retire, unchanged when both happen in the same cycle. When full, issue is blocked even if a retire happens in that cycle (no full-bypass).
- Wrap-around: pointers are IdW bits and wrap naturally. Full/empty is decided by count, not by pointer equality.
- Writeback to the head entry in the same cycle as it retires cannot occur, because the head must already be done to retire; a writeback to it is an error.
- flush_i (synchronous):
  - Clears every valid/done bit; head = tail = count = 0.
  - An issue or writeback in the flush cycle is discarded.
  - err_o is unaffected; it is cleared only by reset.
- Asynchronous reset mid-operation returns all state to the reset values immediately, regardless of outstanding entries.

Test Plan:
- In-order completion, Depth=8: issue tags 1,2,3 to groups 0,1,2; write back IDs 0,1,2 in order → tags 1,2,3 retire one per cycle with the matching results; occupancy goes 3→0.
- Out-of-order completion: issue IDs 0..3. Write back ID3 in cycle 5, ID1 in cycle 6, ID0 in cycle 7, ID2 in cycle 8, with out_ready_i=1 → out_valid_o first rises in cycle 8 (ID0); ID1 retires in cycle 9, ID2 and ID3 in cycles 10–11, in order.
- Full and wrap-around: issue 8 with out_ready_i=0 → issue_ready_o=0 and occupancy_o=8. Complete and retire 3, then issue 3 more → issue_id_o values are 0,1,2, and the retire order continues 3..7,0,1,2.
- Backpressure: head done, out_ready_i held 0 for 4 cycles → out_valid_o stays 1 and result_o stays stable; retires on the cycle out_ready_i=1.
- Errors: writeback on ID5 with no entry allocated; writeback from group 2 to an entry issued to group 1; duplicate writeback to a done entry → each is dropped, err_o=1 and stays set, and the buffer contents are unchanged.
- Flush and reset: 5 in flight, assert flush_i with a simultaneous issue and writeback → next cycle occupancy_o=0, busy_o=0, out_valid_o=0, issue_id_o=0. Repeat with rst_ni pulsed low mid-cycle → same state, and err_o=0.
